// File: rtl/pipe_controller_if.sv
// Control-path bundle between the 5-stage datapath and its pipelined controller.
// The datapath side is the master; the controller is the slave.
interface pipe_controller_if #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned ALUCONT_W = 3
);
    logic [5:0]           op;
    logic [5:0]           funct;
    logic [REG_AW-1:0]    id_rs;
    logic [REG_AW-1:0]    id_rt;
    logic                 ex_branch_taken;
    logic                 mem_busy;

    logic                 id_jump;
    logic                 stall_f;
    logic                 flush_ifid;
    logic                 illegal;
    logic                 ex_regdst;
    logic                 ex_alusrc;
    logic                 ex_branch;
    logic                 ex_bne;
    logic                 ex_zeroext;
    logic [ALUCONT_W-1:0] ex_alucont;
    logic                 mem_memread;
    logic                 mem_memwrite;
    logic                 wb_memtoreg;
    logic                 wb_regwrite;

    modport master (
        output op, funct, id_rs, id_rt, ex_branch_taken, mem_busy,
        input  id_jump, stall_f, flush_ifid, illegal,
        input  ex_regdst, ex_alusrc, ex_branch, ex_bne, ex_zeroext, ex_alucont,
        input  mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite
    );

    modport slave (
        input  op, funct, id_rs, id_rt, ex_branch_taken, mem_busy,
        output id_jump, stall_f, flush_ifid, illegal,
        output ex_regdst, ex_alusrc, ex_branch, ex_bne, ex_zeroext, ex_alucont,
        output mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite
    );
endinterface

// File: rtl/pipe_controller.sv
// Pipelined controller: ID-stage decode, ID/EX, EX/MEM and MEM/WB control registers,
// plus load-use stall, branch/jump flush and memory-wait freeze generation.
module pipe_controller #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned ALUCONT_W = 3,
    parameter bit          EXT_OPS   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_controller_if.slave   bus
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

    localparam logic [OP_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND   = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR    = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT   = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic                 regdst;
        logic                 alusrc;
        logic                 branch;
        logic                 bne;
        logic                 zeroext;
        logic [ALUCONT_W-1:0] alucont;
        logic                 memread;
        logic                 memwrite;
        logic                 memtoreg;
        logic                 regwrite;
    } ctrl_t;

    typedef struct packed {
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } memctl_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wbctl_t;

    // Pipeline action for this cycle, already resolved by priority.
    typedef enum logic [2:0] {
        ACT_RUN,
        ACT_HOLD,
        ACT_FLUSH_BR,
        ACT_LOAD_USE,
        ACT_JUMP
    } act_t;

    ctrl_t             id_ctrl;
    logic [ALU_W-1:0]  id_alu;
    logic              id_jump_c;
    logic              illegal_c;
    logic              uses_rt;

    ctrl_t             id_ex;
    logic [REG_AW-1:0] ex_rt;
    memctl_t           ex_mem;
    wbctl_t            mem_wb;

    logic              br_taken;
    logic              load_use;
    act_t              act;
    logic              squash_idex;

    // ID-stage decode; anything not recognised yields an all-zero bundle.
    always_comb begin
        id_ctrl   = '0;
        id_alu    = '0;
        id_jump_c = 1'b0;
        illegal_c = 1'b0;
        uses_rt   = 1'b0;
        case (bus.op)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                case (bus.funct)
                    FN_ADD:  id_alu = ALU_ADD;
                    FN_SUB:  id_alu = ALU_SUB;
                    FN_AND:  id_alu = ALU_AND;
                    FN_OR:   id_alu = ALU_OR;
                    FN_SLT:  id_alu = ALU_SLT;
                    default: illegal_c = 1'b1;
                endcase
                if (!illegal_c) begin
                    id_ctrl.regdst   = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                end
            end
            OP_ADDI: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.regwrite = 1'b1;
                id_alu           = ALU_ADD;
            end
            OP_BEQ: begin
                uses_rt        = 1'b1;
                id_ctrl.branch = 1'b1;
                id_alu         = ALU_ADD;
            end
            OP_J: begin
                id_jump_c = 1'b1;
            end
            OP_LB: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memread  = 1'b1;
                id_ctrl.memtoreg = 1'b1;
                id_ctrl.regwrite = 1'b1;
                id_alu           = ALU_ADD;
            end
            OP_SB: begin
                uses_rt          = 1'b1;
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memwrite = 1'b1;
                id_alu           = ALU_ADD;
            end
            OP_BNE: begin
                if (EXT_OPS) begin
                    uses_rt        = 1'b1;
                    id_ctrl.branch = 1'b1;
                    id_ctrl.bne    = 1'b1;
                    id_alu         = ALU_ADD;
                end else begin
                    illegal_c = 1'b1;
                end
            end
            OP_ANDI, OP_ORI: begin
                if (EXT_OPS) begin
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.zeroext  = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                    id_alu           = (bus.op == OP_ORI) ? ALU_OR : ALU_AND;
                end else begin
                    illegal_c = 1'b1;
                end
            end
            OP_SLTI: begin
                if (EXT_OPS) begin
                    id_ctrl.alusrc   = 1'b1;
                    id_ctrl.regwrite = 1'b1;
                    id_alu           = ALU_SLT;
                end else begin
                    illegal_c = 1'b1;
                end
            end
            default: illegal_c = 1'b1;
        endcase
        id_ctrl.alucont = ALUCONT_W'(id_alu);
    end

    // Hazard detection and priority resolution.
    always_comb begin
        br_taken = id_ex.branch & (bus.ex_branch_taken ^ id_ex.bne);
        load_use = id_ex.memread & (ex_rt != '0) &
                   ((ex_rt == bus.id_rs) | (uses_rt & (ex_rt == bus.id_rt)));
        act = ACT_RUN;
        if (bus.mem_busy) begin
            act = ACT_HOLD;
        end else if (br_taken) begin
            act = ACT_FLUSH_BR;
        end else if (load_use) begin
            act = ACT_LOAD_USE;
        end else if (id_jump_c) begin
            act = ACT_JUMP;
        end
        squash_idex = (act == ACT_FLUSH_BR) || (act == ACT_LOAD_USE);
    end

    // Control registers; a memory wait freezes every stage, including a taken branch in EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex  <= '0;
            ex_rt  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else if (act != ACT_HOLD) begin
            id_ex  <= squash_idex ? ctrl_t'('0) : id_ctrl;
            ex_rt  <= bus.id_rt;
            ex_mem <= '{memread:  id_ex.memread,
                        memwrite: id_ex.memwrite,
                        memtoreg: id_ex.memtoreg,
                        regwrite: id_ex.regwrite};
            mem_wb <= '{memtoreg: ex_mem.memtoreg,
                        regwrite: ex_mem.regwrite};
        end
    end

    assign bus.id_jump      = id_jump_c;
    assign bus.illegal      = illegal_c;
    assign bus.stall_f      = rst_n & ((act == ACT_HOLD) | (act == ACT_LOAD_USE));
    assign bus.flush_ifid   = rst_n & ((act == ACT_FLUSH_BR) | (act == ACT_JUMP));

    assign bus.ex_regdst    = id_ex.regdst;
    assign bus.ex_alusrc    = id_ex.alusrc;
    assign bus.ex_branch    = id_ex.branch;
    assign bus.ex_bne       = id_ex.bne;
    assign bus.ex_zeroext   = id_ex.zeroext;
    assign bus.ex_alucont   = id_ex.alucont;
    assign bus.mem_memread  = ex_mem.memread;
    assign bus.mem_memwrite = ex_mem.memwrite;
    assign bus.wb_memtoreg  = mem_wb.memtoreg;
    assign bus.wb_regwrite  = mem_wb.regwrite;

endmodule
